seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexing scan controller that shares one BCD-to-7-segment decoder between DIGITS display positions. It holds a frame of BCD digits, steps through them at a programmable slot rate, and presents one digit code per slot on `bcd`, which feeds the shared decoder. It drives the active-low digit enables `an_n`, accepts new frames through a load/ack handshake applied only at frame boundaries, and inserts a guard gap between slots to prevent ghosting.

## Interface
- `DIGITS`, default 4: number of multiplexed digit positions, range 2–8.
- `PRESCALE`, default 1000: clock cycles per digit slot, minimum 4.
- `clk`  in  1: clock. All state changes on the rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `load`  in  1: request to accept `digits_in` as the next frame.
- `digits_in`  in  4*DIGITS: BCD digits; digit i is `[4i+3:4i]`, and digit 0 is least significant.
- `load_ack`  out  1: one-cycle pulse when a pending frame becomes active.
- `bcd`  out  4: code sent to the shared decoder. 4'hF means blank, because the decoder maps non-decimal codes to all-off.
- `an_n`  out  DIGITS: digit enables, active-low, at most one low at a time.
- `frame_done`  out  1: one-cycle pulse on the last cycle of digit DIGITS-1's slot.

## Operation
- Registers:
  - `active` frame, 4*DIGITS bits.
  - `pending` frame and `pend_v` flag.
  - digit index `idx`, 0..DIGITS-1.
  - slot counter `cnt`, 0..PRESCALE-1.
  - state.
- Reset values:
  - `active` = all 4'hF, so every digit is blank.
  - `pend_v` = 0, `idx` = 0, `cnt` = 0, state = IDLE.
  - Outputs: `bcd` = 4'hF, `an_n` = all 1, `load_ack` = 0, `frame_done` = 0.
- States:
  - IDLE: `an_n` all 1, `bcd` = 4'hF. Entered only from reset. Leaves to GUARD with `idx` = 0 on the first cycle `pend_v` = 1. On that transition the pending frame becomes active and `load_ack` pulses.
  - GUARD: `cnt` = 0..1. `an_n` all 1; `bcd` already carries the code for `idx`. Moves to SHOW when `cnt` = 1.
  - SHOW: `cnt` = 2..PRESCALE-1. `an_n[idx]` = 0, all other bits 1. When `cnt` = PRESCALE-1:
    - `cnt` returns to 0 and the state returns to GUARD.
    - `idx` increments, wrapping from DIGITS-1 to 0.
    - On the wrap, `frame_done` pulses. If `pend_v` = 1, the pending frame becomes active, `pend_v` clears and `load_ack` pulses in that same cycle.
- Load handshake:
  - `load` = 1 captures `digits_in` into `pending` and sets `pend_v` on that edge.
  - A second `load` before the frame boundary overwrites `pending`. Only one `load_ack` is produced, and it covers the latest data.
  - If `load` coincides with the wrap cycle, that new data becomes active directly and `load_ack` pulses. The data captured earlier is discarded.
- Digit code:
  - `bcd` = `active[4*idx+3:4*idx]`, registered.
  - Non-decimal codes pass through unchanged and show blank.
- Reset during any state returns every register to its reset value immediately. A partial slot is never completed.

## Timing
- Slot length is exactly PRESCALE cycles: 2 guard cycles plus PRESCALE-2 display cycles. A frame is DIGITS*PRESCALE cycles.
- `bcd` changes on the first GUARD cycle of a slot, 2 cycles before its `an_n` bit goes low.
- Latency from `load` to `load_ack`:
  - From IDLE: 1 cycle.
  - Otherwise: up to one frame.
- The new frame is displayed starting with digit 0 in the first slot after `load_ack`.
- `frame_done` and `load_ack` are asserted in the same cycle when a boundary load occurs.

## Configuration
- Macro: `SEG_SCAN_BLANK_LZ_EN`.
- Defined: leading-zero blanking.
  - Working down from digit DIGITS-1, each digit equal to 0 is sent as 4'hF until the first nonzero digit.
  - Digit 0 is never blanked.
  - The blanking mask is computed when a frame becomes active and stored alongside it.
- Undefined: no mask logic exists and all digits are shown as stored.

## Test plan
- Reset, then one cycle of `load` with `digits_in` = 16'h1234 (DIGITS=4, PRESCALE=8) → `load_ack` 1 cycle later. Slots then show `bcd` 4,3,2,1, each with `an_n` low for 6 of 8 cycles (1110, 1101, 1011, 0111). `frame_done` pulses at cycle 32 of the frame.
- `load` 16'h5678 mid-frame, then `load` 16'h9999 before the boundary → a single `load_ack`, coinciding with `frame_done`. The next frame shows 9,9,9,9.
- `load` asserted exactly on the wrap cycle with 16'h0042 → immediate `load_ack`. With `SEG_SCAN_BLANK_LZ_EN` the slots show 2,4,F,F; without it they show 2,4,0,0.
- `digits_in` = 16'h0000 with the macro defined → slots show 0,F,F,F, so digit 0 stays visible.
- Assert `rst` during a SHOW slot → on that same edge `an_n` = 1111, `bcd` = F and the state is IDLE. No `load_ack` follows until a new `load` arrives.
- Over any 1000-cycle window, check that at most one bit of `an_n` is low at a time and that every `an_n` transition is separated by at least the 2 guard cycles.

Source files
------------

// File: rtl/seg_scan_ctrl_if.sv
// Bundle of load handshake and display drive signals for seg_scan_ctrl.
// The master drives frames in; the slave (the scan controller) drives the display.
interface seg_scan_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   digits_in;
  logic                  load_ack;
  logic [3:0]            bcd;
  logic [DIGITS-1:0]     an_n;
  logic                  frame_done;

  modport master (
    output load, digits_in,
    input  load_ack, bcd, an_n, frame_done
  );

  modport slave (
    input  load, digits_in,
    output load_ack, bcd, an_n, frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: one shared BCD decoder, guard gap per slot.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_BLANK_LZ_EN.
module seg_scan_ctrl #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000
) (
  input  logic           clk,
  input  logic           rst,
  seg_scan_ctrl_if.slave bus
);

  localparam int IDX_W = $clog2(DIGITS);
  localparam int CNT_W = $clog2(PRESCALE);
  localparam int FRM_W = 4 * DIGITS;

  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] GUARD_END = CNT_W'(1);
  localparam logic [3:0]       BLANK     = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    GUARD,
    SHOW
  } state_t;

  state_t            state_q, state_d;
  logic [FRM_W-1:0]  active_q, active_d;
  logic [FRM_W-1:0]  pending_q, pending_d;
  logic              pend_v_q, pend_v_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        bcd_q, bcd_d;
  logic [DIGITS-1:0] an_n_q, an_n_d;

  logic              take;
  logic [FRM_W-1:0]  take_frame;
  logic [FRM_W-1:0]  shifted;
  logic [3:0]        code;
  logic              load_ack;
  logic              frame_done;

`ifdef SEG_SCAN_BLANK_LZ_EN
  logic [DIGITS-1:0] mask_q, mask_d;

  // Zeros above the most significant nonzero digit are blanked; digit 0 always shows.
  function automatic logic [DIGITS-1:0] lz_mask(input logic [FRM_W-1:0] frame);
    logic              leading;
    logic [DIGITS-1:0] m;
    leading = 1'b1;
    m       = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (leading && frame[4*i +: 4] == 4'd0) m[i] = 1'b1;
      else                                    leading = 1'b0;
    end
    return m;
  endfunction
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    active_d   = active_q;
    pending_d  = pending_q;
    pend_v_d   = pend_v_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    take       = 1'b0;
    take_frame = pending_q;
    load_ack   = 1'b0;
    frame_done = 1'b0;

    if (bus.load) begin
      pending_d = bus.digits_in;
      pend_v_d  = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (pend_v_q) begin
          state_d  = GUARD;
          idx_d    = '0;
          cnt_d    = '0;
          take     = 1'b1;
          load_ack = 1'b1;
          if (!bus.load) pend_v_d = 1'b0;
        end
      end
      GUARD: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == GUARD_END) state_d = SHOW;
      end
      SHOW: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = GUARD;
          if (idx_q == IDX_LAST) begin
            idx_d      = '0;
            frame_done = 1'b1;
            // A load landing on the wrap cycle supersedes anything already pending.
            if (bus.load) begin
              take       = 1'b1;
              take_frame = bus.digits_in;
              load_ack   = 1'b1;
              pend_v_d   = 1'b0;
            end else if (pend_v_q) begin
              take     = 1'b1;
              load_ack = 1'b1;
              pend_v_d = 1'b0;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (take) active_d = take_frame;

    shifted = active_d >> {idx_d, 2'b00};
    code    = shifted[3:0];
`ifdef SEG_SCAN_BLANK_LZ_EN
    mask_d = mask_q;
    if (take) mask_d = lz_mask(take_frame);
    if (mask_d[idx_d]) code = BLANK;
`endif

    // Outputs are registered from next-state values so they line up with the state register.
    bcd_d  = (state_d == IDLE) ? BLANK : code;
    an_n_d = (state_d == SHOW) ? ~(DIGITS'(1) << idx_d) : '1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  // NOTE: the frame registers are reset too, so a reset always blanks the display.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      active_q  <= {DIGITS{BLANK}};
      pending_q <= {DIGITS{BLANK}};
      pend_v_q  <= 1'b0;
      idx_q     <= '0;
      cnt_q     <= '0;
      bcd_q     <= BLANK;
      an_n_q    <= '1;
`ifdef SEG_SCAN_BLANK_LZ_EN
      mask_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      pend_v_q  <= pend_v_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      an_n_q    <= an_n_d;
`ifdef SEG_SCAN_BLANK_LZ_EN
      mask_q    <= mask_d;
`endif
    end
  end

  assign bus.bcd        = bcd_q;
  assign bus.an_n       = an_n_q;
  assign bus.load_ack   = load_ack;
  assign bus.frame_done = frame_done;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl with DIGITS=4, PRESCALE=8.
// Expected blank-vs-zero values follow SEG_SCAN_BLANK_LZ_EN when it is defined.
module tb_seg_scan_ctrl;

  localparam int DIGITS   = 4;
  localparam int PRESCALE = 8;

`ifdef SEG_SCAN_BLANK_LZ_EN
  localparam logic [3:0] LZ = 4'hF;
`else
  localparam logic [3:0] LZ = 4'h0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  seg_scan_ctrl_if #(.DIGITS(DIGITS)) bus ();

  seg_scan_ctrl #(
    .DIGITS  (DIGITS),
    .PRESCALE(PRESCALE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One full slot starting at its first guard cycle. Optionally drives load during cycle load_c.
  task automatic check_slot(input int d, input logic [3:0] exp_bcd, input bit last,
                            input bit exp_ack, input int load_c, input logic [15:0] load_d);
    logic [3:0] exp_an;
    for (int c = 0; c < PRESCALE; c++) begin
      cyc();
      if (c == load_c) begin
        bus.load      = 1'b1;
        bus.digits_in = load_d;
      end else begin
        bus.load = 1'b0;
      end
      @(negedge clk);
      exp_an = (c < 2) ? 4'hF : ~(4'b0001 << d);
      check($sformatf("bcd d%0d c%0d", d, c), bus.bcd, exp_bcd);
      check($sformatf("an_n d%0d c%0d", d, c), bus.an_n, exp_an);
      check($sformatf("frame_done d%0d c%0d", d, c), bus.frame_done,
            (last && c == PRESCALE - 1) ? 1 : 0);
      check($sformatf("load_ack d%0d c%0d", d, c), bus.load_ack,
            (last && exp_ack && c == PRESCALE - 1) ? 1 : 0);
    end
  endtask

  initial begin
    logic [3:0] prev_an;
    int         since;
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.load      = 1'b0;
    bus.digits_in = '0;

    repeat (3) cyc();
    @(negedge clk);
    check("reset an_n", bus.an_n, 4'hF);
    check("reset bcd", bus.bcd, 4'hF);
    check("reset load_ack", bus.load_ack, 0);
    check("reset frame_done", bus.frame_done, 0);
    cyc();
    rst = 1'b0;

    // Load from IDLE: acknowledge one cycle later.
    cyc();
    bus.load      = 1'b1;
    bus.digits_in = 16'h1234;
    @(negedge clk);
    check("idle ack early", bus.load_ack, 0);
    cyc();
    bus.load = 1'b0;
    @(negedge clk);
    check("idle ack", bus.load_ack, 1);
    check("idle an_n", bus.an_n, 4'hF);

    // Frame 1234 with two mid-frame loads; only the latest is acknowledged at the boundary.
    check_slot(0, 4'h4, 0, 0, -1, 16'h0);
    check_slot(1, 4'h3, 0, 0, 3, 16'h5678);
    check_slot(2, 4'h2, 0, 0, 4, 16'h9999);
    check_slot(3, 4'h1, 1, 1, -1, 16'h0);

    // Frame 9999; a load on the wrap cycle is taken directly.
    check_slot(0, 4'h9, 0, 0, -1, 16'h0);
    check_slot(1, 4'h9, 0, 0, -1, 16'h0);
    check_slot(2, 4'h9, 0, 0, -1, 16'h0);
    check_slot(3, 4'h9, 1, 1, 7, 16'h0042);

    // Frame 0042, then an all-zero frame loaded on the wrap cycle.
    check_slot(0, 4'h2, 0, 0, -1, 16'h0);
    check_slot(1, 4'h4, 0, 0, -1, 16'h0);
    check_slot(2, LZ, 0, 0, -1, 16'h0);
    check_slot(3, LZ, 1, 1, 7, 16'h0000);

    // Frame 0000: digit 0 always visible; no pending data, so no ack.
    check_slot(0, 4'h0, 0, 0, -1, 16'h0);
    check_slot(1, LZ, 0, 0, -1, 16'h0);
    check_slot(2, LZ, 0, 0, -1, 16'h0);
    check_slot(3, LZ, 1, 0, -1, 16'h0);

    // Leave a pending frame, then reset in the middle of a SHOW slot.
    check_slot(0, 4'h0, 0, 0, 3, 16'h7777);
    check_slot(1, LZ, 0, 0, -1, 16'h0);
    repeat (4) cyc();
    cyc();
    @(negedge clk);
    check("pre-reset an_n", bus.an_n, 4'b1011);
    cyc();
    rst = 1'b1;
    #1;
    check("async reset an_n", bus.an_n, 4'hF);
    check("async reset bcd", bus.bcd, 4'hF);
    check("async reset load_ack", bus.load_ack, 0);
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      @(negedge clk);
      check($sformatf("post-reset load_ack %0d", i), bus.load_ack, 0);
      check($sformatf("post-reset an_n %0d", i), bus.an_n, 4'hF);
      check($sformatf("post-reset bcd %0d", i), bus.bcd, 4'hF);
    end

    // Restart and watch a long window for one-cold enables and guard spacing.
    cyc();
    bus.load      = 1'b1;
    bus.digits_in = 16'h1234;
    cyc();
    bus.load = 1'b0;
    @(negedge clk);
    check("restart ack", bus.load_ack, 1);
    prev_an = bus.an_n;
    since   = 100;
    for (int i = 0; i < 1000; i++) begin
      cyc();
      @(negedge clk);
      since++;
      check($sformatf("an_n onehot %0d", i), ($countones(~bus.an_n) <= 1) ? 1 : 0, 1);
      if (bus.an_n !== prev_an) begin
        check($sformatf("an_n gap %0d", i), (since >= 2) ? 1 : 0, 1);
        since = 0;
      end
      prev_an = bus.an_n;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
